fma16_arb: RTL and testbench

FMA16_ARB -- requirements
Module: fma16_arb

---
 rtl/fma16_pkg.sv | 78 +++++++
 rtl/fma16_arb_fma16.sv | 109 ++++++++++
 rtl/fma16_arb.sv | 140 ++++++++++++++
 tb/tb_fma16_arb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fma16_pkg.sv
// Shared opcode/state/rounding types, constants and fp16 field helpers.
package fma16_pkg;

  typedef enum logic [2:0] {
    OP_FADD    = 3'b000,
    OP_FSUB    = 3'b001,
    OP_FMUL    = 3'b010,
    OP_FMADD   = 3'b011,
    OP_FMSUB   = 3'b100,
    OP_FNMADD  = 3'b101,
    OP_FNMSUB  = 3'b110,
    OP_ILLEGAL = 3'b111
  } fma_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // rn rounds toward negative infinity, rp toward positive infinity.
  typedef enum logic [1:0] {
    RM_RZ  = 2'b00,
    RM_RNE = 2'b01,
    RM_RP  = 2'b10,
    RM_RN  = 2'b11
  } rm_e;

  localparam logic [15:0] QNAN     = 16'h7E00;
  localparam logic [15:0] HALF_ONE = 16'h3C00;

  // Datapath control derived from the opcode.
  typedef struct packed {
    logic mul;
    logic add;
    logic negz;
    logic negr;
  } dec_t;

  function automatic dec_t op_decode(input fma_op_e op);
    dec_t d;
    d = '0;
    case (op)
      OP_FADD:   d = '{mul: 1'b0, add: 1'b1, negz: 1'b0, negr: 1'b0};
      OP_FSUB:   d = '{mul: 1'b0, add: 1'b1, negz: 1'b1, negr: 1'b0};
      OP_FMUL:   d = '{mul: 1'b1, add: 1'b0, negz: 1'b0, negr: 1'b0};
      OP_FMADD:  d = '{mul: 1'b1, add: 1'b1, negz: 1'b0, negr: 1'b0};
      OP_FMSUB:  d = '{mul: 1'b1, add: 1'b1, negz: 1'b1, negr: 1'b0};
      OP_FNMADD: d = '{mul: 1'b1, add: 1'b1, negz: 1'b0, negr: 1'b1};
      OP_FNMSUB: d = '{mul: 1'b1, add: 1'b1, negz: 1'b1, negr: 1'b1};
      default:   d = '0;
    endcase
    return d;
  endfunction

  function automatic logic h_is_nan(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
  endfunction

  function automatic logic h_is_inf(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] == 10'd0);
  endfunction

  function automatic logic h_is_zero(input logic [15:0] h);
    return h[14:0] == 15'd0;
  endfunction

  // Significand including the hidden bit (absent for subnormals).
  function automatic logic [10:0] h_sig(input logic [15:0] h);
    return {(h[14:10] != 5'd0), h[9:0]};
  endfunction

  // Effective biased exponent: subnormals share the weight of exponent 1.
  function automatic logic [4:0] h_exp(input logic [15:0] h);
    return (h[14:10] == 5'd0) ? 5'd1 : h[14:10];
  endfunction

endpackage

// File: rtl/fma16_arb_fma16.sv
// Combinational half-precision fused multiply-add with a single rounding.
// The exact product and addend are summed in an 82-bit fixed-point window
// (LSB weight 2^-48), wide enough that no bits are lost before rounding.
module fma16
  import fma16_pkg::*;
(
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic [15:0] z_i,
  input  logic [1:0]  rm_i,
  input  dec_t        dec_i,
  output logic [15:0] result_o
);

  localparam int W = 82;

  rm_e          rm;
  logic [15:0]  yv;
  logic         ps, zs, rs, zero_s;
  logic [10:0]  mx, my, mz, q11;
  logic [21:0]  prod;
  logic [6:0]   pshift, lead, rpos;
  logic [5:0]   zshift;
  logic [W-1:0] pa, za, mag, below;
  logic         guard, sticky, inc;
  logic [16:0]  enc_base, enc_r;
  logic [15:0]  ovf_res;
  logic         any_nan, p_inf, z_inf, p_invalid;

  // Align, add, normalise, round and resolve special operands.
  always_comb begin
    rm       = rm_e'(rm_i);
    // Add-only ops multiply by 1.0; multiply-only ops add a zero of the product's sign.
    yv       = dec_i.mul ? y_i : HALF_ONE;
    ps       = x_i[15] ^ yv[15] ^ dec_i.negr;
    zs       = dec_i.add ? (z_i[15] ^ dec_i.negz ^ dec_i.negr) : ps;
    mx       = h_sig(x_i);
    my       = h_sig(yv);
    mz       = dec_i.add ? h_sig(z_i) : 11'd0;
    prod     = 22'(mx) * 22'(my);
    pshift   = 7'(h_exp(x_i)) + 7'(h_exp(yv)) - 7'd2;
    zshift   = 6'(h_exp(z_i)) + 6'd23;
    pa       = W'(prod) << pshift;
    za       = W'(mz) << zshift;
    rs       = ps;
    mag      = '0;
    if (ps == zs) begin
      mag = pa + za;
      rs  = ps;
    end else if (pa >= za) begin
      mag = pa - za;
      rs  = ps;
    end else begin
      mag = za - pa;
      rs  = zs;
    end

    lead = 7'd0;
    for (int i = 0; i < W; i++) begin
      if (mag[i]) lead = 7'(i);
    end
    // Bit 34 is weight 2^-14, the smallest normal; below it the LSB is fixed at 2^-24.
    rpos     = (lead >= 7'd34) ? (lead - 7'd10) : 7'd24;
    q11      = 11'(mag >> rpos);
    guard    = mag[rpos - 7'd1];
    below    = (W'(1) << (rpos - 7'd1)) - W'(1);
    sticky   = |(mag & below);

    case (rm)
      RM_RZ:   inc = 1'b0;
      RM_RNE:  inc = guard & (sticky | q11[0]);
      RM_RP:   inc = (guard | sticky) & ~rs;
      default: inc = (guard | sticky) & rs;
    endcase

    // Adding the significand with its hidden bit to (exp-1)<<10 yields the
    // packed exponent/fraction; rounding carries ripple into the exponent.
    enc_base = (lead >= 7'd34) ? (17'(lead - 7'd34) << 10) : 17'd0;
    enc_r    = enc_base + 17'(q11) + 17'(inc);

    case (rm)
      RM_RZ:   ovf_res = {rs, 15'h7BFF};
      RM_RNE:  ovf_res = {rs, 15'h7C00};
      RM_RP:   ovf_res = rs ? 16'hFBFF : 16'h7C00;
      default: ovf_res = rs ? 16'hFC00 : 16'h7BFF;
    endcase

    zero_s    = (ps == zs) ? ps : (rm == RM_RN);
    any_nan   = h_is_nan(x_i) || h_is_nan(yv) || (dec_i.add && h_is_nan(z_i));
    p_inf     = h_is_inf(x_i) || h_is_inf(yv);
    p_invalid = (h_is_inf(x_i) && h_is_zero(yv)) || (h_is_zero(x_i) && h_is_inf(yv));
    z_inf     = dec_i.add && h_is_inf(z_i);

    if (any_nan || p_invalid || (p_inf && z_inf && (ps != zs))) begin
      result_o = QNAN;
    end else if (p_inf) begin
      result_o = {ps, 15'h7C00};
    end else if (z_inf) begin
      result_o = {zs, 15'h7C00};
    end else if (mag == '0) begin
      result_o = {zero_s, 15'd0};
    end else if (enc_r >= 17'h07C00) begin
      result_o = ovf_res;
    end else begin
      result_o = {rs, enc_r[14:0]};
    end
  end

endmodule

// File: rtl/fma16_arb.sv
// Two-requester round-robin front end sharing one fma16 datapath.
// One operation in flight: IDLE accepts, EXEC waits EXEC_CYCLES, RESP holds
// the result until the granted requester takes it.
module fma16_arb
  import fma16_pkg::*;
#(
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][2:0]  req_op,
  input  logic [1:0][15:0] req_x,
  input  logic [1:0][15:0] req_y,
  input  logic [1:0][15:0] req_z,
  input  logic [1:0][1:0]  req_rm,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [15:0]      rsp_result,
  output logic             busy,
  output logic             illegal_op
);

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic [15:0] result_q, result_d;
  logic        illegal_q, illegal_d;
  logic        gnt_q, gnt_sel, accept;
  fma_op_e     op_q;
  logic [15:0] x_q, y_q, z_q;
  logic [1:0]  rm_q;
  dec_t        dec;
  logic [15:0] dp_result;

  // Pick a requester: the single valid one, or on a tie the one not served last.
  always_comb begin
    gnt_sel = 1'b0;
    if (req_valid == 2'b11) gnt_sel = ~last_q;
    else if (req_valid[1])  gnt_sel = 1'b1;
    accept    = (state_q == ST_IDLE) && (req_valid != 2'b00) && !reset;
    req_ready = 2'b00;
    if (accept) req_ready[gnt_sel] = 1'b1;
  end

  // Capture the accepted operation; the datapath sees only these registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= OP_FADD;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      rm_q  <= '0;
      gnt_q <= 1'b0;
    end else if (accept) begin
      op_q  <= fma_op_e'(req_op[gnt_sel]);
      x_q   <= req_x[gnt_sel];
      y_q   <= req_y[gnt_sel];
      z_q   <= req_z[gnt_sel];
      rm_q  <= req_rm[gnt_sel];
      gnt_q <= gnt_sel;
    end
  end

  assign dec = op_decode(op_q);

  fma16 u_fma16 (
    .x_i      (x_q),
    .y_i      (y_q),
    .z_i      (z_q),
    .rm_i     (rm_q),
    .dec_i    (dec),
    .result_o (dp_result)
  );

  // FSM, settle counter, round-robin pointer, result and sticky flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      last_q    <= 1'b1;
      result_q  <= 16'h0000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and response outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    rsp_valid = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (fma_op_e'(req_op[gnt_sel]) == OP_ILLEGAL) begin
            state_d   = ST_RESP;
            result_d  = QNAN;
            illegal_d = 1'b1;
          end else begin
            state_d = ST_EXEC;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          result_d = dp_result;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        if (rsp_ready[gnt_q]) begin
          state_d = ST_IDLE;
          last_d  = gnt_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign rsp_result = result_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_fma16_arb.sv
module tb_fma16_arb;

  logic             clk;
  logic             reset;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0][2:0]  req_op;
  logic [1:0][15:0] req_x, req_y, req_z;
  logic [1:0][1:0]  req_rm;
  logic [15:0]      rsp_result;
  logic             busy, illegal_op;

  logic [1:0]       b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [1:0][2:0]  b_req_op;
  logic [1:0][15:0] b_req_x, b_req_y, b_req_z;
  logic [1:0][1:0]  b_req_rm;
  logic [15:0]      b_rsp_result;
  logic             b_busy, b_illegal_op;

  fma16_arb #(.EXEC_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_rm(req_rm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .busy(busy), .illegal_op(illegal_op)
  );

  fma16_arb #(.EXEC_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
    .req_x(b_req_x), .req_y(b_req_y), .req_z(b_req_z), .req_rm(b_req_rm),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_result(b_rsp_result),
    .busy(b_busy), .illegal_op(b_illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        who;
    logic [2:0]  op;
    logic [15:0] x, y, z;
    logic [1:0]  rm;
    logic [15:0] expect_res;
  } vec_t;

  vec_t vecs [16];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic seen_ill = 1'b0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one table vector on the EXEC_CYCLES=1 instance and check it end to end.
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    logic [1:0] want;
    want = 2'b01 << v.who;
    req_op[v.who] = v.op;
    req_x[v.who]  = v.x;
    req_y[v.who]  = v.y;
    req_z[v.who]  = v.z;
    req_rm[v.who] = v.rm;
    req_valid     = want;
    #1;
    chk("req_ready", idx, 32'(req_ready), 32'(want));
    tick();
    req_valid = 2'b00;
    if (v.op == 3'b111) seen_ill = 1'b1;
    n = 0;
    while (rsp_valid == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    chk("latency", idx, 32'(n), (v.op == 3'b111) ? 32'd0 : 32'd1);
    chk("rsp_valid", idx, 32'(rsp_valid), 32'(want));
    chk("result", idx, 32'(rsp_result), 32'(v.expect_res));
    chk("illegal_flag", idx, 32'(illegal_op), 32'(seen_ill));
    $display("vec %0d req%0d op=%b x=%h y=%h z=%h rm=%b -> result=%h (lat %0d)",
             idx, v.who, v.op, v.x, v.y, v.z, v.rm, rsp_result, n);
    rsp_ready = want;
    tick();
    rsp_ready = 2'b00;
    chk("busy_after", idx, 32'(busy), 32'd0);
  endtask

  initial begin
    int n, cyc, last_gc, ng, g, bad;

    vecs[0]  = '{1'b0, 3'b010, 16'h4000, 16'h4200, 16'h0000, 2'b01, 16'h4600};
    vecs[1]  = '{1'b1, 3'b011, 16'h4000, 16'h4200, 16'h3C00, 2'b01, 16'h4700};
    vecs[2]  = '{1'b0, 3'b000, 16'h3C00, 16'h0000, 16'h3C00, 2'b01, 16'h4000};
    vecs[3]  = '{1'b1, 3'b001, 16'h4200, 16'h0000, 16'h3C00, 2'b01, 16'h4000};
    vecs[4]  = '{1'b0, 3'b100, 16'h4000, 16'h4200, 16'h3C00, 2'b01, 16'h4500};
    vecs[5]  = '{1'b1, 3'b101, 16'h4000, 16'h4200, 16'h3C00, 2'b01, 16'hC700};
    vecs[6]  = '{1'b0, 3'b110, 16'h4000, 16'h4200, 16'h3C00, 2'b01, 16'hC500};
    vecs[7]  = '{1'b1, 3'b000, 16'h3C00, 16'h0000, 16'hBC00, 2'b01, 16'h0000};
    vecs[8]  = '{1'b0, 3'b000, 16'h3C00, 16'h0000, 16'hBC00, 2'b11, 16'h8000};
    vecs[9]  = '{1'b1, 3'b010, 16'h7C00, 16'h0000, 16'h0000, 2'b01, 16'h7E00};
    vecs[10] = '{1'b0, 3'b010, 16'h7BFF, 16'h4000, 16'h0000, 2'b01, 16'h7C00};
    vecs[11] = '{1'b1, 3'b010, 16'h7BFF, 16'h4000, 16'h0000, 2'b00, 16'h7BFF};
    vecs[12] = '{1'b0, 3'b000, 16'h3C00, 16'h0000, 16'h1000, 2'b01, 16'h3C00};
    vecs[13] = '{1'b1, 3'b000, 16'h3C00, 16'h0000, 16'h1000, 2'b10, 16'h3C01};
    vecs[14] = '{1'b0, 3'b010, 16'h0001, 16'h3C00, 16'h0000, 2'b01, 16'h0001};
    vecs[15] = '{1'b1, 3'b111, 16'h4000, 16'h4200, 16'h3C00, 2'b01, 16'h7E00};

    reset = 1'b1;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_op = '0; req_x = '0; req_y = '0; req_z = '0; req_rm = '0;
    b_req_valid = 2'b00; b_rsp_ready = 2'b00;
    b_req_op = '0; b_req_x = '0; b_req_y = '0; b_req_z = '0; b_req_rm = '0;

    // Reset state, with a request pending that must not be acknowledged.
    repeat (2) @(posedge clk);
    #1;
    req_valid = 2'b01;
    #1;
    chk("rst_req_ready", 0, 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 0, 32'(rsp_valid), 32'd0);
    chk("rst_busy", 0, 32'(busy), 32'd0);
    chk("rst_illegal", 0, 32'(illegal_op), 32'd0);
    chk("rst_result", 0, 32'(rsp_result), 32'd0);
    req_valid = 2'b00;
    reset = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Response held for 5 cycles; requester 1 waits until after the handshake.
    req_op[0] = 3'b010; req_x[0] = 16'h4000; req_y[0] = 16'h4200; req_z[0] = 16'h0000; req_rm[0] = 2'b01;
    req_op[1] = 3'b000; req_x[1] = 16'h3C00; req_y[1] = 16'h0000; req_z[1] = 16'h3C00; req_rm[1] = 2'b01;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    n = 0;
    while (rsp_valid == 2'b00 && n < 20) begin tick(); n++; end
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("hold_rsp_valid", k, 32'(rsp_valid), 32'd1);
      chk("hold_result", k, 32'(rsp_result), 32'h4600);
      chk("hold_req_ready", k, 32'(req_ready), 32'd0);
      $display("hold cycle %0d rsp_valid=%b result=%h req_ready=%b", k, rsp_valid, rsp_result, req_ready);
      tick();
    end
    rsp_ready = 2'b01;
    #1;
    chk("hs_cycle_req_ready", 0, 32'(req_ready), 32'd0);
    tick();
    rsp_ready = 2'b00;
    chk("after_hs_req_ready", 0, 32'(req_ready), 32'd2);
    chk("after_hs_rsp_valid", 0, 32'(rsp_valid), 32'd0);
    tick();
    req_valid = 2'b00;
    n = 0;
    while (rsp_valid == 2'b00 && n < 20) begin tick(); n++; end
    chk("held_req1_valid", 0, 32'(rsp_valid), 32'd2);
    chk("held_req1_result", 0, 32'(rsp_result), 32'h4000);
    chk("illegal_sticky", 0, 32'(illegal_op), 32'd1);
    $display("held req1 served result=%h illegal_op=%b", rsp_result, illegal_op);
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;

    // Reset clears the sticky flag and the round-robin pointer.
    reset = 1'b1;
    #1;
    chk("illegal_cleared", 0, 32'(illegal_op), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Both requesters valid continuously, responses always taken.
    req_op[0] = 3'b010; req_x[0] = 16'h4000; req_y[0] = 16'h4200; req_z[0] = 16'h0000;
    req_op[1] = 3'b000; req_x[1] = 16'h3C00; req_y[1] = 16'h0000; req_z[1] = 16'h3C00;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    ng = 0; cyc = 0; last_gc = 0;
    while (ng < 4 && cyc < 40) begin
      #1;
      if (req_ready != 2'b00) begin
        g = req_ready[1] ? 1 : 0;
        chk("rr_grant", ng, 32'(g), 32'(ng % 2));
        chk("rr_busy_low", ng, 32'(busy), 32'd0);
        if (ng > 0) chk("rr_gap", ng, 32'(cyc - last_gc), 32'd3);
        $display("rr grant %0d -> req%0d at cycle %0d", ng, g, cyc);
        last_gc = cyc;
        ng++;
      end else begin
        chk("rr_busy_high", cyc, 32'(busy), 32'd1);
      end
      if (rsp_valid != 2'b00)
        chk("rr_result", cyc, 32'(rsp_result), rsp_valid[1] ? 32'h4000 : 32'h4600);
      @(posedge clk);
      cyc++;
    end
    chk("rr_count", 0, 32'(ng), 32'd4);
    #1;
    req_valid = 2'b00;
    n = 0;
    while (rsp_valid == 2'b00 && n < 20) begin tick(); n++; end
    chk("rr_last_valid", 0, 32'(rsp_valid), 32'd2);
    chk("rr_last_result", 0, 32'(rsp_result), 32'h4000);
    tick();
    rsp_ready = 2'b00;

    // EXEC_CYCLES=4 instance: full latency, then reset in the middle of EXEC.
    b_req_op[0] = 3'b010; b_req_x[0] = 16'h4000; b_req_y[0] = 16'h4200; b_req_rm[0] = 2'b01;
    b_req_valid = 2'b01;
    #1;
    chk("b_req_ready", 0, 32'(b_req_ready), 32'd1);
    tick();
    b_req_valid = 2'b00;
    n = 0;
    while (b_rsp_valid == 2'b00 && n < 30) begin tick(); n++; end
    chk("b_latency", 0, 32'(n), 32'd4);
    chk("b_result", 0, 32'(b_rsp_result), 32'h4600);
    $display("ec4 op result=%h latency=%0d", b_rsp_result, n);
    b_rsp_ready = 2'b01;
    tick();
    b_rsp_ready = 2'b00;

    b_req_valid = 2'b01;
    tick();
    b_req_valid = 2'b00;
    tick();
    chk("b_busy_exec", 1, 32'(b_busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("b_rst_busy", 1, 32'(b_busy), 32'd0);
    chk("b_rst_rsp_valid", 1, 32'(b_rsp_valid), 32'd0);
    chk("b_rst_req_ready", 1, 32'(b_req_ready), 32'd0);
    chk("b_rst_result", 1, 32'(b_rsp_result), 32'd0);
    chk("b_rst_illegal", 1, 32'(b_illegal_op), 32'd0);
    $display("ec4 reset mid-exec busy=%b rsp_valid=%b result=%h", b_busy, b_rsp_valid, b_rsp_result);
    tick();
    reset = 1'b0;
    b_rsp_ready = 2'b01;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (b_rsp_valid != 2'b00 || b_busy) bad++;
    end
    b_rsp_ready = 2'b00;
    chk("b_no_rsp_after_reset", 1, 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
